// File: rtl/johnson_seq_pkg.sv
// Shared types and Johnson-code helpers for the johnson_seq_ctrl block.
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned JC_MAX_W = 32;

    // Position in the 2n-phase sequence: ones fill from the bottom, then drain from the bottom.
    function automatic int unsigned jc_idx(input logic [JC_MAX_W-1:0] q, input int unsigned n);
        int unsigned pop;
        pop = 0;
        for (int unsigned i = 0; i < JC_MAX_W; i++) begin
            if (i < n && q[i]) pop++;
        end
        return q[n-1] ? (2 * n - pop) : pop;
    endfunction

    // A legal Johnson code has at most one boundary between adjacent unequal bits.
    function automatic logic jc_valid(input logic [JC_MAX_W-1:0] q, input int unsigned n);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i + 1 < JC_MAX_W; i++) begin
            if (i + 1 < n && q[i] != q[i+1]) edges++;
        end
        return edges <= 1;
    endfunction

endpackage

// File: rtl/johnson_seq_ctrl_core.sv
// N-bit twisted-ring register with advance enable and synchronous clear.
module johnson_core #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)     q_d = '0;
        else if (en) q_d = {q_q[N-2:0], ~q_q[N-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Start/stop/single-step controller for a Johnson counter with revolution counting
// and illegal-state recovery.
module johnson_seq_ctrl
    import johnson_seq_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned IDX_W = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             step,
    input  logic [CNT_W-1:0] num_revs,
    output logic [N-1:0]     q,
    output logic [2*N-1:0]   phase,
    output logic [IDX_W-1:0] phase_idx,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             err
);

    localparam logic [N-1:0] WRAP_CODE = {1'b1, {(N-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             stepm_q, stepm_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    logic [N-1:0]     q_w;
    logic             illegal;
    logic             adv;
    logic             wrap_evt;

    assign illegal  = !jc_valid(JC_MAX_W'(q_w), N);
    assign adv      = (state_q == RUN) && !stop && (!stepm_q || step);
    assign wrap_evt = adv && (q_w == WRAP_CODE);

    johnson_core #(.N(N)) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .clr  (stop || illegal),
        .q    (q_w)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stepm_d = stepm_q;
        err_d   = err_q;
        wrap_d  = wrap_evt;
        if (illegal) err_d = 1'b1;
        if (stop) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = RUN;
                    rem_d   = num_revs;
                    stepm_d = step_mode;
                    if (!illegal) err_d = 1'b0;
                end
                RUN: if (wrap_evt && rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            stepm_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            stepm_q <= stepm_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q         = q_w;
    assign phase_idx = IDX_W'(jc_idx(JC_MAX_W'(q_w), N));
    assign phase     = (2*N)'(1) << phase_idx;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign wrap      = wrap_q;
    assign err       = err_q;

endmodule
